// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 fetch constants, state type and PC helper
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Sequential successor of a 64-bit PC; wraps silently at 2^64.
    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + 64'(PC_INC);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry instruction+PC buffer used while decode stalls
import legv8_pkg::*;

module fetch_skid #(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [N-1:0]       load_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       pc,
    output logic               full
);

    // Occupancy flag: clear beats load, load beats unload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // Payload is captured on load and otherwise held; it is only read while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (load && !clear) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch: PC, imem handshake, IF/ID register
import legv8_pkg::*;

module fetch_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               PCSrc,
    input  logic [N-1:0]       PCBranch,
    input  logic               stall_D,
    input  logic               flush_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [N-1:0]       pc_D,
    output logic               valid_D
);

    fetch_state_t       state, state_n;
    logic [N-1:0]       pc_f, pc_n;
    logic [N-1:0]       tgt, tgt_n;
    logic [INSTR_W-1:0] instr_n;
    logic [N-1:0]       pc_d_n;
    logic               valid_n;

    logic               skid_load;
    logic               skid_unload;
    logic               skid_clear;
    logic [INSTR_W-1:0] skid_instr;
    logic [N-1:0]       skid_pc;
    logic               skid_full;

    fetch_skid #(.N(N)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_f),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .full       (skid_full)
    );

    // A request is outstanding in REQ, and also in DROP where the reply is thrown away.
    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = pc_f;

    // Next-state, next-PC and IF/ID update; a redirect overrides everything else.
    always_comb begin
        state_n     = state;
        pc_n        = pc_f;
        tgt_n       = tgt;
        instr_n     = instr_D;
        pc_d_n      = pc_D;
        valid_n     = valid_D;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (PCSrc) begin
            // Kill the wrong-path instruction in IF/ID and anything parked in the skid.
            valid_n    = 1'b0;
            instr_n    = NOP_INSTR;
            skid_clear = 1'b1;
            case (state)
                IDLE: begin
                    pc_n    = PCBranch;
                    state_n = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_n = PCBranch;
                    end else begin
                        // Address must stay put until the in-flight reply returns.
                        tgt_n   = PCBranch;
                        state_n = DROP;
                    end
                end
                FULL: begin
                    pc_n    = PCBranch;
                    state_n = REQ;
                end
                DROP: begin
                    if (imem_ack) begin
                        pc_n    = PCBranch;
                        state_n = REQ;
                    end else begin
                        tgt_n = PCBranch;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            // Without new data, a flush or a non-stalled decode leaves a bubble behind.
            if (flush_D || !stall_D) begin
                valid_n = 1'b0;
                instr_n = NOP_INSTR;
            end
            case (state)
                IDLE: begin
                    state_n = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_n = pc_f + N'(PC_INC);
                        if (!stall_D) begin
                            instr_n = imem_rdata;
                            pc_d_n  = pc_f;
                            valid_n = 1'b1;
                        end else begin
                            // Decode is holding IF/ID, so park the reply and stop fetching.
                            skid_load = 1'b1;
                            state_n   = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall_D) begin
                        instr_n     = skid_instr;
                        pc_d_n      = skid_pc;
                        valid_n     = 1'b1;
                        skid_unload = 1'b1;
                        state_n     = REQ;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc_n    = tgt;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc_f  <= RESET_PC;
            tgt   <= '0;
        end else begin
            state <= state_n;
            pc_f  <= pc_n;
            tgt   <= tgt_n;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= '0;
            valid_D <= 1'b0;
        end else begin
            instr_D <= instr_n;
            pc_D    <= pc_d_n;
            valid_D <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [63:0] PCBranch;
    logic        stall_D;
    logic        flush_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int cnt   = 0;

    fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCSrc      (PCSrc),
        .PCBranch   (PCBranch),
        .stall_D    (stall_D),
        .flush_D    (flush_D),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .valid_D    (valid_D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks the lat-th cycle a request is up, returning the low address bits.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (cnt >= lat - 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr[31:0];
                    cnt        = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt      = cnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        PCSrc    = 1'b0;
        PCBranch = 64'h0;
        stall_D  = 1'b0;
        flush_D  = 1'b0;
        repeat (2) step();
        check("rst_req",   imem_req,  0);
        check("rst_addr",  imem_addr, 0);
        check("rst_valid", valid_D,   0);
        check("rst_instr", instr_D,   0);
        check("rst_pcd",   pc_D,      0);
        reset = 1'b0;

        // Back-to-back single-cycle acks
        step();
        check("first_req",   imem_req,  1);
        check("first_addr",  imem_addr, 0);
        check("first_valid", valid_D,   0);
        step();
        check("s0_valid", valid_D,   1);
        check("s0_pcd",   pc_D,      0);
        check("s0_addr",  imem_addr, 64'h4);
        step();
        check("s4_pcd",   pc_D,      64'h4);
        check("s4_instr", instr_D,   32'h4);
        check("s4_addr",  imem_addr, 64'h8);

        // Stall four cycles starting with the ack for 0x8
        stall_D = 1'b1;
        step();
        check("stall_req",  imem_req, 0);
        check("stall_pcd",  pc_D,     64'h4);
        check("stall_vld",  valid_D,  1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_req", imem_req, 0);
            check("stall_hold_pcd", pc_D,     64'h4);
        end
        stall_D = 1'b0;
        step();
        check("unskid_pcd",   pc_D,      64'h8);
        check("unskid_instr", instr_D,   32'h8);
        check("unskid_valid", valid_D,   1);
        check("unskid_req",   imem_req,  1);
        check("unskid_addr",  imem_addr, 64'hC);
        step();
        check("sC_pcd",  pc_D,      64'hC);
        check("sC_addr", imem_addr, 64'h10);

        // Three-cycle ack latency on 0x10
        lat = 3;
        step();
        check("lat_c2_valid", valid_D,   0);
        check("lat_c2_addr",  imem_addr, 64'h10);
        check("lat_c2_req",   imem_req,  1);
        step();
        check("lat_c3_addr",  imem_addr, 64'h10);
        check("lat_c3_req",   imem_req,  1);
        step();
        check("lat_done_vld", valid_D,   1);
        check("lat_done_pcd", pc_D,      64'h10);
        check("lat_done_adr", imem_addr, 64'h14);

        // Redirect to 0x100 in cycle 2 of the miss to 0x14
        step();
        check("drop_c2_addr", imem_addr, 64'h14);
        PCSrc    = 1'b1;
        PCBranch = 64'h100;
        step();
        PCSrc = 1'b0;
        check("drop_hold_addr", imem_addr, 64'h14);
        check("drop_hold_req",  imem_req,  1);
        check("drop_valid",     valid_D,   0);
        step();
        check("drop_tgt_addr", imem_addr, 64'h100);
        check("drop_discard",  valid_D,   0);
        step();
        check("tgt_c2_valid", valid_D, 0);
        step();
        check("tgt_c3_valid", valid_D, 0);
        step();
        check("tgt_valid", valid_D,   1);
        check("tgt_pcd",   pc_D,      64'h100);
        check("tgt_instr", instr_D,   32'h100);
        check("tgt_addr",  imem_addr, 64'h104);

        // Flush together with stall
        stall_D = 1'b1;
        flush_D = 1'b1;
        step();
        check("flush_valid", valid_D,   0);
        check("flush_instr", instr_D,   0);
        check("flush_addr",  imem_addr, 64'h104);
        check("flush_req",   imem_req,  1);
        stall_D = 1'b0;
        flush_D = 1'b0;
        step();
        check("flush_c2_vld", valid_D, 0);
        step();
        check("after_fl_vld", valid_D, 1);
        check("after_fl_pcd", pc_D,    64'h104);

        // Redirect coinciding with an ack
        lat      = 1;
        PCSrc    = 1'b1;
        PCBranch = 64'h200;
        step();
        PCSrc = 1'b0;
        check("redir_ack_addr",  imem_addr, 64'h200);
        check("redir_ack_valid", valid_D,   0);
        check("redir_ack_instr", instr_D,   0);
        step();
        check("r200_valid", valid_D,   1);
        check("r200_pcd",   pc_D,      64'h200);
        check("r200_addr",  imem_addr, 64'h204);

        // Reset in the middle of a miss
        lat = 3;
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_req",   imem_req,  0);
        check("mid_rst_addr",  imem_addr, 0);
        check("mid_rst_valid", valid_D,   0);
        check("mid_rst_pcd",   pc_D,      0);
        check("mid_rst_instr", instr_D,   0);
        step();
        reset = 1'b0;
        step();
        check("restart_req",  imem_req,  1);
        check("restart_addr", imem_addr, 0);
        step();
        check("restart_c2_vld", valid_D, 0);
        step();
        check("restart_c3_vld", valid_D, 0);
        step();
        check("restart_valid", valid_D,   1);
        check("restart_pcd",   pc_D,      0);
        check("restart_addr4", imem_addr, 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
